// File: rtl/ysyx_22041461_ifu_if.sv
// Bus bundle between the IFU, the PC stage, instruction memory and the IDU.
// The master modport is the IFU side; the slave modport is its environment.
interface ysyx_22041461_ifu_if;
  logic        pc_valid;
  logic [63:0] pc;
  logic        pc_ready;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        mem_resp_err;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [1:0]  inst_fault;

  modport master (
    input  pc_valid, pc, mem_req_ready, mem_resp_valid, mem_resp_data,
           mem_resp_err, flush, inst_ready,
    output pc_ready, mem_req_valid, mem_req_addr, inst_valid, inst,
           inst_pc, inst_fault
  );

  modport slave (
    output pc_valid, pc, mem_req_ready, mem_resp_valid, mem_resp_data,
           mem_resp_err, flush, inst_ready,
    input  pc_ready, mem_req_valid, mem_req_addr, inst_valid, inst,
           inst_pc, inst_fault
  );
endinterface

// File: rtl/ysyx_22041461_ifu.sv
// Instruction fetch unit: one outstanding doubleword read per fetched
// instruction, with misalignment, access-error and timeout reporting.
module ysyx_22041461_ifu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22041461_ifu_if.master        bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_timer;
  logic [31:0] r_inst;
  logic [63:0] r_pc;
  logic [1:0]  r_fault;
  logic        w_expired;

  // Timer has been counting for TIMEOUT cycles once this edge is taken.
  assign w_expired = (r_timer >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.pc_valid) w_next = (bus.pc[1:0] != 2'b00) ? HOLD : REQ;
      REQ: begin
        if (bus.flush)              w_next = bus.mem_req_ready ? DRAIN : IDLE;
        else if (bus.mem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (bus.flush)                            w_next = bus.mem_resp_valid ? IDLE : DRAIN;
        else if (bus.mem_resp_valid || w_expired) w_next = HOLD;
      end
      DRAIN:   if (bus.mem_resp_valid || w_expired) w_next = IDLE;
      HOLD:    if (bus.flush || bus.inst_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Every entry into WAIT or DRAIN restarts the window, so a stale response
  // after a redirect gets a full TIMEOUT period to be swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 8'd0;
    end else if (w_next != r_state) begin
      r_timer <= 8'd0;
    end else if ((r_state == WAIT || r_state == DRAIN) && r_timer != 8'hFF) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= 64'd0;
      r_inst  <= 32'd0;
      r_fault <= 2'b00;
    end else if (r_state == IDLE && bus.pc_valid) begin
      r_pc    <= bus.pc;
      r_inst  <= 32'd0;
      r_fault <= (bus.pc[1:0] != 2'b00) ? 2'b01 : 2'b00;
    end else if (r_state == WAIT && w_next == HOLD) begin
      if (bus.mem_resp_valid) begin
        r_inst  <= r_pc[2] ? bus.mem_resp_data[63:32] : bus.mem_resp_data[31:0];
        r_fault <= bus.mem_resp_err ? 2'b10 : 2'b00;
      end else begin
        r_inst  <= 32'd0;
        r_fault <= 2'b11;
      end
    end
  end

  assign bus.pc_ready      = (r_state == IDLE);
  assign bus.mem_req_valid = (r_state == REQ);
  assign bus.mem_req_addr  = {r_pc[63:3], 3'b000};
  assign bus.inst_valid    = (r_state == HOLD);
  assign bus.inst          = r_inst;
  assign bus.inst_pc       = r_pc;
  assign bus.inst_fault    = r_fault;
endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// Directed bench for the IFU: a vector table of complete fetches plus
// hand-written sequences for flush, timeout, hold and reset corner cases.
module tb_ysyx_22041461_ifu;
  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  ysyx_22041461_ifu_if bus();
  ysyx_22041461_ifu #(.TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] data;
    logic        err;
    int          dly;
    logic [31:0] inst;
    logic [63:0] addr;
    logic [1:0]  fault;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_fetch(input vec_t v);
    bus.pc_valid = 1'b1;
    bus.pc       = v.pc;
    step();
    bus.pc_valid = 1'b0;
    if (v.fault == 2'b01) begin
      check("misaligned_no_req", bus.mem_req_valid, 1'b0);
    end else begin
      check("req_valid", bus.mem_req_valid, 1'b1);
      check("req_addr", bus.mem_req_addr, v.addr);
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      check("wait_no_req", bus.mem_req_valid, 1'b0);
      repeat (v.dly) step();
      check("wait_not_valid", bus.inst_valid, 1'b0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = v.data;
      bus.mem_resp_err   = v.err;
      step();
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
    end
    check("hold_valid", bus.inst_valid, 1'b1);
    check("hold_inst", bus.inst, v.inst);
    check("hold_pc", bus.inst_pc, v.pc);
    check("hold_fault", bus.inst_fault, v.fault);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("retire_valid", bus.inst_valid, 1'b0);
    check("retire_pc_ready", bus.pc_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{64'h8000_0004, 64'h00100093_00000413, 1'b0, 2, 32'h00100093, 64'h8000_0000, 2'b00};
    vecs[1] = '{64'h8000_0000, 64'h00100093_00000413, 1'b0, 1, 32'h00000413, 64'h8000_0000, 2'b00};
    vecs[2] = '{64'h8000_0000, 64'h11112222_33334444, 1'b1, 0, 32'h33334444, 64'h8000_0000, 2'b10};
    vecs[3] = '{64'h8000_0002, 64'h0,                 1'b0, 0, 32'h0,        64'h0,           2'b01};
    vecs[4] = '{64'h1234_567C, 64'hCAFEBABE_0BADF00D, 1'b0, 0, 32'hCAFEBABE, 64'h1234_5678, 2'b00};
    vecs[5] = '{64'h8000_0001, 64'h0,                 1'b0, 0, 32'h0,        64'h0,           2'b01};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 3, 32'h5A5A5A5A,
                64'hFFFF_FFFF_FFFF_FFF8, 2'b00};

    rst = 1'b1;
    bus.pc_valid = 1'b0; bus.pc = 64'd0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 64'd0; bus.mem_resp_err = 1'b0;
    bus.flush = 1'b0; bus.inst_ready = 1'b0;
    #1;
    check("rst_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_req_addr", bus.mem_req_addr, 64'd0);
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 64'd0);
    check("rst_fault", bus.inst_fault, 2'b00);
    step();
    rst = 1'b0;
    step();
    check("rst_pc_ready", bus.pc_ready, 1'b1);

    for (int i = 0; i < 7; i++) do_fetch(vecs[i]);

    // Timeout: HOLD with fault 11 exactly 4 cycles after entering WAIT.
    bus.pc_valid = 1'b1; bus.pc = 64'h8000_0008;
    step();
    bus.pc_valid = 1'b0; bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tmo_still_wait", bus.inst_valid, 1'b0);
    end
    step();
    check("tmo_valid", bus.inst_valid, 1'b1);
    check("tmo_fault", bus.inst_fault, 2'b11);
    check("tmo_inst", bus.inst, 32'd0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;

    // Flush in WAIT, flush again in DRAIN, stale response 3 cycles later.
    bus.pc_valid = 1'b1; bus.pc = 64'h8000_0000;
    step();
    bus.pc_valid = 1'b0; bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0; bus.flush = 1'b1;
    step();
    check("drain_pc_ready", bus.pc_ready, 1'b0);
    check("drain_no_req", bus.mem_req_valid, 1'b0);
    step();
    bus.flush = 1'b0;
    check("drain_flush_ignored", bus.pc_ready, 1'b0);
    step();
    check("drain_still", bus.pc_ready, 1'b0);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'hDEADBEEF_DEADBEEF;
    step();
    bus.mem_resp_valid = 1'b0;
    check("drain_drop_valid", bus.inst_valid, 1'b0);
    check("drain_idle", bus.pc_ready, 1'b1);
    step();
    check("drain_drop_valid2", bus.inst_valid, 1'b0);
    do_fetch('{64'h8000_0010, 64'h11111111_00000513, 1'b0, 1, 32'h00000513, 64'h8000_0010, 2'b00});

    // HOLD stability with inst_ready low, then flush beats inst_ready.
    bus.pc_valid = 1'b1; bus.pc = 64'h8000_0004;
    step();
    bus.mem_req_ready = 1'b1; bus.pc = 64'h9000_0000;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'h00100093_00000413;
    step();
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_inst", bus.inst, 32'h00100093);
      check("stall_pc", bus.inst_pc, 64'h8000_0004);
      check("stall_fault", bus.inst_fault, 2'b00);
      check("stall_pc_ready", bus.pc_ready, 1'b0);
      step();
    end
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.inst_ready = 1'b1;
    step();
    bus.flush = 1'b0; bus.inst_ready = 1'b0;
    check("flush_hold_valid", bus.inst_valid, 1'b0);
    check("flush_hold_idle", bus.pc_ready, 1'b1);

    // Flush in REQ: without handshake -> IDLE; request held stable meanwhile.
    bus.pc_valid = 1'b1; bus.pc = 64'h8000_0020;
    step();
    bus.pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("req_hold_valid", bus.mem_req_valid, 1'b1);
      check("req_hold_addr", bus.mem_req_addr, 64'h8000_0020);
      step();
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("req_flush_idle", bus.pc_ready, 1'b1);
    check("req_flush_no_req", bus.mem_req_valid, 1'b0);

    // Flush in REQ with handshake -> DRAIN, response swallowed.
    bus.pc_valid = 1'b1; bus.pc = 64'h8000_0024;
    step();
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.mem_req_ready = 1'b1;
    step();
    bus.flush = 1'b0; bus.mem_req_ready = 1'b0;
    check("req_hs_flush_drain", bus.pc_ready, 1'b0);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'h0;
    step();
    bus.mem_resp_valid = 1'b0;
    check("req_hs_drop_valid", bus.inst_valid, 1'b0);
    check("req_hs_idle", bus.pc_ready, 1'b1);

    // Flush in IDLE does not block acceptance; stray response in IDLE ignored.
    bus.mem_resp_valid = 1'b1;
    step();
    bus.mem_resp_valid = 1'b0;
    check("idle_resp_ignored", bus.pc_ready, 1'b1);
    bus.flush = 1'b1; bus.pc_valid = 1'b1; bus.pc = 64'h8000_0008;
    step();
    bus.flush = 1'b0; bus.pc_valid = 1'b0;
    check("idle_flush_accept", bus.mem_req_valid, 1'b1);
    check("idle_flush_addr", bus.mem_req_addr, 64'h8000_0008);

    // Asynchronous reset while in REQ.
    #2 rst = 1'b1;
    #1;
    check("arst_req_valid", bus.mem_req_valid, 1'b0);
    check("arst_addr", bus.mem_req_addr, 64'd0);
    check("arst_inst_pc", bus.inst_pc, 64'd0);
    check("arst_inst_valid", bus.inst_valid, 1'b0);
    rst = 1'b0;
    step();
    check("arst_idle", bus.pc_ready, 1'b1);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'h12345678_9ABCDEF0;
    step();
    bus.mem_resp_valid = 1'b0;
    check("arst_late_resp_valid", bus.inst_valid, 1'b0);
    check("arst_late_resp_idle", bus.pc_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ysyx_22041461_ifu.md
YSYX_22041461_IFU -- requirements
Module: ysyx_22041461_IFU

Interface
REQ-001 Parameter: TIMEOUT, default 255, WAIT/DRAIN cycles before an outstanding fetch is abandoned (1..255).
REQ-002 One clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 pc_valid  input  1  PC stage offers a fetch address.
REQ-006 pc  input  64  fetch address from PC stage.
REQ-007 pc_ready  output  1  IFU accepts pc this cycle.
REQ-008 mem_req_valid  output  1  instruction-memory read request.
REQ-009 mem_req_addr  output  64  8-byte-aligned read address.
REQ-010 mem_req_ready  input  1  memory accepts request.
REQ-011 mem_resp_valid  input  1  read data returned (one cycle pulse).
REQ-012 mem_resp_data  input  64  returned doubleword.
REQ-013 mem_resp_err  input  1  access error, qualified by mem_resp_valid.
REQ-014 flush  input  1  abandon current fetch (redirect).
REQ-015 inst_valid  output  1  instruction presented to IDU.
REQ-016 inst_ready  input  1  IDU consumes instruction.
REQ-017 inst  output  32  fetched instruction word.
REQ-018 inst_pc  output  64  address of inst.
REQ-019 inst_fault  output  2  00 none, 01 misaligned, 10 access error, 11 timeout.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, DRAIN, HOLD; all outputs registered or decoded from state only.
REQ-021 IDLE: pc_ready=1; on pc_valid capture pc into inst_pc; pc[1:0]!=0 -> HOLD, inst=0, inst_fault=01, no memory request; else -> REQ.
REQ-022 REQ: mem_req_valid=1, mem_req_addr={inst_pc[63:3],3'b000}, held stable until mem_req_ready; handshake -> WAIT, timer=0.
REQ-023 WAIT: timer increments each cycle; on mem_resp_valid inst = inst_pc[2] ? data[63:32] : data[31:0], inst_fault = err ? 10 : 00 -> HOLD.
REQ-024 WAIT: timer reaching TIMEOUT without response -> HOLD, inst=0, inst_fault=11.
REQ-025 HOLD: inst_valid=1, inst/inst_pc/inst_fault stable; inst_ready -> IDLE; no new pc accepted before IDLE (minimum 4 cycles per instruction).
REQ-026 flush in IDLE: no effect, pc_ready stays 1 and pc_valid is still accepted that cycle.
REQ-027 flush in REQ without handshake -> IDLE; flush in REQ with mem_req_ready same cycle -> DRAIN.
REQ-028 flush in WAIT -> DRAIN; if mem_resp_valid in the same cycle, response discarded -> IDLE.
REQ-029 flush in HOLD -> IDLE, instruction dropped, inst_valid deasserts next cycle even if inst_ready was high (flush wins).
REQ-030 DRAIN: discard next mem_resp_valid -> IDLE; timer reaching TIMEOUT -> IDLE; flush in DRAIN ignored.
REQ-031 mem_resp_valid in IDLE, REQ or HOLD SHALL be ignored without state change.
REQ-032 At most one memory request outstanding at any time.
REQ-033 Timer SHALL be 8 bits, saturating, never wrapping.

Reset
REQ-034 rst asserted SHALL immediately force IDLE, timer=0, inst=0, inst_pc=0, inst_fault=00, inst_valid=0, mem_req_valid=0, mem_req_addr=0; pc_ready=1 after release.
REQ-035 Reset mid-fetch SHALL abandon the request; a response arriving after release is ignored per REQ-031.

Verification
REQ-036 pc=0x8000_0004, mem ready at once, resp data=0x00100093_00000413 after 2 cycles -> inst=0x00100093, inst_pc=0x8000_0004, fault=00, mem_req_addr=0x8000_0000.
REQ-037 pc=0x8000_0002 -> HOLD with inst_fault=01, inst=0, mem_req_valid never asserted.
REQ-038 mem_resp_err=1 on fetch of 0x8000_0000 -> inst_fault=10; no response with TIMEOUT=4 -> inst_fault=11 exactly 4 cycles after entering WAIT.
REQ-039 flush in WAIT, response 3 cycles later with 0xDEADBEEF -> response dropped, inst_valid stays 0, next pc 0x8000_0010 fetched correctly.
REQ-040 inst_ready held low 10 cycles in HOLD -> inst, inst_pc, inst_fault stable, pc_ready=0 throughout; then flush -> inst_valid 0 next cycle.
REQ-041 rst asserted asynchronously in REQ -> mem_req_valid and all outputs 0 before next clk edge; state IDLE after release.
